train_seq_ctrl: RTL
===================

TRAIN_SEQ_CTRL -- requirements
Module: train_seq_ctrl

Interface
REQ-001 Parameter NUM_STEPS, default 10, meaning the number of training steps per run; legal range 2..15.
REQ-002 Parameter LAST_PHASE, default 9, meaning the final controller phase code per step; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 stall  input  1  holds step and controller for the cycle.
REQ-007 abort  input  1  terminates a run and returns to IDLE.
REQ-008 step  output  4  current training-step index driven to the datapath.
REQ-009 controller  output  4  current phase code driven to the datapath.
REQ-010 busy  output  1  high while in RUN.
REQ-011 upd_en  output  1  weight-update strobe.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with registered state and registered step/controller.
REQ-014 IDLE: step=0, controller=0, busy=0, done=0; start=1 with abort=0 SHALL move to RUN on the next edge.
REQ-015 On RUN entry, step=0 and controller=0; busy SHALL be 1 in the first RUN cycle (1-cycle start-to-busy latency).
REQ-016 In RUN with stall=0, controller SHALL increment by 1 per cycle; at controller==LAST_PHASE it SHALL wrap to 0 and step SHALL increment by 1 in the same edge.
REQ-017 In RUN with stall=1, step, controller and state SHALL hold.
REQ-018 At step==NUM_STEPS-1, controller==LAST_PHASE and stall=0, the FSM SHALL go to DONE, with step=0 and controller=0.
REQ-019 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE; start in DONE SHALL be ignored.
REQ-020 Unstalled run length SHALL be NUM_STEPS*(LAST_PHASE+1) RUN cycles; each stall cycle adds exactly one cycle.
REQ-021 upd_en SHALL be combinational and equal busy AND (controller==LAST_PHASE) AND (step!=0) AND NOT stall; step 0 never produces an update.
REQ-022 abort=1 in RUN or DONE SHALL force IDLE with step=0 and controller=0 on the next edge, and no done pulse SHALL be issued.
REQ-023 abort SHALL take priority over stall and start; stall SHALL take priority over advance.
REQ-024 start while busy SHALL be ignored and SHALL NOT restart the run.
REQ-025 step and controller SHALL never exceed NUM_STEPS-1 and LAST_PHASE respectively.

Reset
REQ-026 rst=1 SHALL, on the next edge, force IDLE, step=0, controller=0, busy=0 and done=0, overriding all other inputs including mid-run.
REQ-027 upd_en SHALL be 0 in the cycle following reset.

Configuration
REQ-028 Macro TRAIN_SEQ_CYCCNT_EN defined: the block SHALL add output cyc_cnt[15:0], which clears on RUN entry and on rst, increments once per busy cycle (stalled or not), saturates at 16'hFFFF and holds its value in IDLE.
REQ-029 Macro TRAIN_SEQ_CYCCNT_EN undefined: the cyc_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package train_seq_pkg SHALL hold the state enum (IDLE/RUN/DONE), the 4-bit step and controller width constants, and the default LAST_PHASE=9.
REQ-031 One sub-module, train_phase_cnt, SHALL implement the wrapping controller counter with enable (!stall), clear and wrap-pulse output; the step counter and FSM SHALL live in the top.

Verification
REQ-032 rst mid-run at step=3, controller=5 -> next cycle step=0, controller=0, busy=0, done=0.
REQ-033 start pulse, no stall, defaults -> busy for 100 cycles, controller sequence 0..9 repeated, step 0..9, done high for one cycle at cycle 101, then IDLE.
REQ-034 Defaults, full run -> upd_en pulses exactly 9 times, each at controller=9 with step=1..9, and never at step 0.
REQ-035 stall=1 for 3 cycles at step=2, controller=9 -> values held and no upd_en during the stall; the wrap occurs on the first unstalled edge; done arrives at cycle 104.
REQ-036 abort asserted with stall=1 at step=4 -> IDLE next cycle with no done pulse; a later start begins again at step=0, controller=0.
REQ-037 With TRAIN_SEQ_CYCCNT_EN, an unstalled default run -> cyc_cnt=100 in IDLE; a re-start clears it to 0 at RUN entry.

Source files
------------

// File: rtl/train_seq_pkg.sv
// Shared types and constants for the training-step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package train_seq_pkg;

  // Datapath widths for the step index and the controller phase code
  localparam int STEP_W = 4;
  localparam int CTRL_W = 4;

  // Default run shape: 10 steps of 10 phases (phase codes 0..9)
  localparam int DEF_NUM_STEPS  = 10;
  localparam int DEF_LAST_PHASE = 9;

  // Sequencer state encoding: IDLE / RUN / DONE
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/train_phase_cnt.sv
// Wrapping phase counter 0..LAST_PHASE with enable, clear and wrap pulse.
// Latency: count updates on the edge after en; wrap_o is combinational.
// Backpressure: en_i low (stall) holds the count; clr_i overrides en_i.
module train_phase_cnt
  import train_seq_pkg::*;
#(
  parameter int LAST_PHASE = DEF_LAST_PHASE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [CTRL_W-1:0] cnt_o,
  output logic              wrap_o
);

  localparam logic [CTRL_W-1:0] LAST_PH = CTRL_W'(LAST_PHASE);

  logic [CTRL_W-1:0] cnt_q, cnt_d;

  // Wrap fires on the advancing edge out of the last phase
  assign wrap_o = en_i && !clr_i && (cnt_q == LAST_PH);
  assign cnt_o  = cnt_q;

  // Next count: clear wins, then wrap to zero, then increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/train_seq_ctrl.sv
// Training-step sequencer: IDLE -> RUN (NUM_STEPS x LAST_PHASE+1 phases) -> DONE.
// Latency: busy one cycle after start; done one cycle after the last phase.
// Backpressure: stall freezes step/controller; abort returns to IDLE. Option: TRAIN_SEQ_CYCCNT_EN adds cyc_cnt.
module train_seq_ctrl
  import train_seq_pkg::*;
#(
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int LAST_PHASE = DEF_LAST_PHASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              abort,
  output logic [STEP_W-1:0] step,
  output logic [CTRL_W-1:0] controller,
  output logic              busy,
  output logic              upd_en,
  output logic              done
`ifdef TRAIN_SEQ_CYCCNT_EN
  ,
  output logic [15:0]       cyc_cnt
`endif
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [CTRL_W-1:0] LAST_PH   = CTRL_W'(LAST_PHASE);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              ph_en, ph_clr, ph_wrap;
  logic [CTRL_W-1:0] ph_cnt;

  // The phase counter only runs in RUN; leaving RUN by any path clears it
  assign ph_clr = abort || (state_q != ST_RUN);
  assign ph_en  = (state_q == ST_RUN) && !stall;

  train_phase_cnt #(
    .LAST_PHASE(LAST_PHASE)
  ) u_phase (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (ph_en),
    .clr_i (ph_clr),
    .cnt_o (ph_cnt),
    .wrap_o(ph_wrap)
  );

  // FSM and step counter next state; abort beats stall, stall beats advance
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        step_d = '0;
        if (start && !abort) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (ph_wrap) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // State and step registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign step       = step_q;
  assign controller = ph_cnt;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  // Update strobe at the end of every step except the first
  assign upd_en     = busy && (ph_cnt == LAST_PH) && (step_q != '0) && !stall;

`ifdef TRAIN_SEQ_CYCCNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Busy-cycle counter: zeroed on RUN entry, saturating, held outside RUN
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == ST_IDLE) && start && !abort) begin
      cyc_d = '0;
    end else if (busy && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Cycle counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule
